conv_weight_stream_gen: RTL and testbench
=========================================

Name: conv_weight_stream_gen

Overview:
- Generates the serial weight stream (valid_weight_in / weight_in) consumed by the 3x3 conv layers, e.g. cnn_conv_3x3_64s1p1.
- Reads a layer's weights from a synchronous on-chip weight memory with fixed read latency.
- Emits one weight per cycle in the order the conv weight buffer expects, with stall support and frame markers.
- Sits between the weight ROM/BRAM and the conv layer's weight input.

Parameters:
- DATA_WIDTH, 32, weight word width
- CHANNEL_NUM_IN, 64, input channels per output channel
- CHANNEL_NUM_OUT, 64, output channels
- KERNEL, 3, kernel width; KERNEL*KERNEL taps per (co,ci)
- ADDR_WIDTH, 16, weight memory address width; must hold BASE_ADDR+TOTAL-1
- BASE_ADDR, 0, address of first weight of this layer
- MEM_LATENCY, 2, cycles from mem_rd_en to valid mem_rd_data (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begin streaming one full weight set
- hold  in  1  stall request; no new memory reads issued while high
- mem_rd_en  out  1  weight memory read enable
- mem_addr  out  ADDR_WIDTH  weight memory read address
- mem_rd_data  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after mem_rd_en
- valid_weight_out  out  1  weight_out valid; drives conv valid_weight_in
- weight_out  out  DATA_WIDTH  weight word; drives conv weight_in
- last_kernel  out  1  high with the last tap (k=KERNEL*KERNEL-1) of each (co,ci)
- last_weight  out  1  high with the final weight of the set
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last weight is emitted

Behaviour:
- Reset (reset=0, async): all outputs 0; FSM to IDLE; counters cleared; in-flight read pipeline flushed. Reset mid-stream abandons the set; no done pulse.
- TOTAL = CHANNEL_NUM_OUT*CHANNEL_NUM_IN*KERNEL*KERNEL.
- Order: co outer, ci middle, k inner (row-major taps); mem_addr = BASE_ADDR + (co*CHANNEL_NUM_IN+ci)*KERNEL*KERNEL + k.
- Implementation: one linear address counter plus tap counter k and pair counter p (co*CIN+ci) for the markers.
- FSM IDLE:
  - start=1 -> FETCH; busy=1 the next cycle; counters zeroed.
  - start ignored while not IDLE.
- FSM FETCH:
  - Each cycle with hold=0: mem_rd_en=1, mem_addr=current, counter++.
  - hold=1: mem_rd_en=0, counter frozen.
  - After issuing read TOTAL-1 -> DRAIN.
- FSM DRAIN:
  - No reads; waits until the valid pipeline is empty.
  - Then done=1 for one cycle, busy=0, -> IDLE.
  - start in the same cycle as done is ignored.
- Read pipeline:
  - MEM_LATENCY-deep shift register carries {valid, last_kernel, last_weight} tags alongside each read.
  - At depth MEM_LATENCY, mem_rd_data and tags are registered to the outputs.
  - Latency: mem_rd_en at cycle t -> valid_weight_out at t+MEM_LATENCY+1.
- hold affects only issue. Reads already in flight still emit, so up to MEM_LATENCY+1 weights may appear after hold rises; the consumer must accept them.
- valid_weight_out=0 -> weight_out holds its last value; markers are 0.
- No gaps introduced by the block: with hold=0 throughout, TOTAL consecutive valid cycles.
- done asserts exactly 1 cycle after the last_weight cycle.
- Width: address arithmetic is done at ADDR_WIDTH; overflow is a parameter error, not handled at runtime.

Decomposition:
- Shared package/include (alongside the conv param defs): TOTAL, TAPS=KERNEL*KERNEL, counter widths via clog2, FSM state encodings IDLE/FETCH/DRAIN.
- One sub-module: conv_weight_rd_pipe, the parameterised MEM_LATENCY tag/valid delay line with output register.
- FSM, counters and address generation stay in the top.

Test Plan (CHANNEL_NUM_IN=2, CHANNEL_NUM_OUT=2, KERNEL=3, MEM_LATENCY=2, BASE_ADDR=100, memory word = address):
- Full stream: start pulse, hold=0 -> 36 consecutive valid weights 100..135; first valid 3 cycles after first mem_rd_en; last_kernel on 108,117,126,135; last_weight on 135; done 1 cycle later; busy low after.
- Stall: hold=1 for 5 cycles after the 10th read -> weights 100..109 plus in-flight words emitted, then gap; resume with no skip/duplicate; total still 36, order intact.
- Ignored start: start pulses during FETCH and in the done cycle -> no restart; exactly 36 weights; a later start in IDLE streams 100..135 again.
- Reset mid-op: reset low after 20 weights -> all outputs 0 immediately; no done; after release, a new start gives a clean 36-weight set from 100.
- Latency sweep: MEM_LATENCY=1 and 4 -> valid_weight_out first at t+2 and t+5; data and markers correct.
- Hold at start: hold=1 when start arrives for 3 cycles -> no mem_rd_en until hold drops; busy=1 throughout; stream then normal.

Source files
------------

// File: rtl/conv_weight_stream_gen_pkg.sv
// Shared types and sizing helpers for the conv weight stream generator.
package conv_weight_stream_gen_pkg;

  // Default layer geometry (matches the 3x3, 64-in / 64-out conv layers)
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_CHANNEL_NUM_IN  = 64;
  localparam int DEF_CHANNEL_NUM_OUT = 64;
  localparam int DEF_KERNEL          = 3;
  localparam int DEF_ADDR_WIDTH      = 16;
  localparam int DEF_MEM_LATENCY     = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Sideband tags that travel with each outstanding memory read
  typedef struct packed {
    logic valid;
    logic last_kernel;
    logic last_weight;
  } rd_tag_t;

  // Taps per (co,ci) pair
  function automatic int calc_taps(input int kernel);
    return kernel * kernel;
  endfunction

  // Weights in one complete set
  function automatic int calc_total(input int cin, input int cout, input int kernel);
    return cout * cin * kernel * kernel;
  endfunction

  // Bits needed to count 0..n-1, never less than one
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_weight_rd_pipe.sv
// Delay line that carries valid/marker tags alongside in-flight memory reads
// and registers the returned word plus tags onto the weight outputs.
module conv_weight_rd_pipe
  import conv_weight_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = DEF_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic                  tag_last_kernel,
  input  logic                  tag_last_weight,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last_kernel,
  output logic                  last_weight,
  output logic                  in_flight
);

  rd_tag_t stage_in [LATENCY];
  rd_tag_t stage_q  [LATENCY];
  rd_tag_t tail;

  // Stage 0 is fed by the issuing read, every later stage by its predecessor
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign stage_in[gi] = rd_tag_t'({issue, tag_last_kernel, tag_last_weight});
    end else begin : g_body
      assign stage_in[gi] = stage_q[gi-1];
    end
  end

  assign tail = stage_q[LATENCY-1];

  // Advance the tag delay line; reset discards every outstanding read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_in[i];
      end
    end
  end

  // Capture the returned word with its tags; data holds while no word arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid       <= 1'b0;
      data        <= '0;
      last_kernel <= 1'b0;
      last_weight <= 1'b0;
    end else begin
      valid       <= tail.valid;
      last_kernel <= tail.valid & tail.last_kernel;
      last_weight <= tail.valid & tail.last_weight;
      if (tail.valid) begin
        data <= mem_rd_data;
      end
    end
  end

  // Anything still travelling, including the word currently on the output
  always_comb begin
    in_flight = valid;
    for (int i = 0; i < LATENCY; i++) begin
      in_flight = in_flight | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/conv_weight_stream_gen.sv
// Streams one layer's weights from a fixed-latency weight memory to a 3x3
// conv layer, co outer / ci middle / tap inner, with stall and frame markers.
module conv_weight_stream_gen
  import conv_weight_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter int KERNEL          = DEF_KERNEL,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int BASE_ADDR       = 0,
  parameter int MEM_LATENCY     = DEF_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  last_kernel,
  output logic                  last_weight,
  output logic                  busy,
  output logic                  done
);

  localparam int TAPS   = calc_taps(KERNEL);
  localparam int TOTAL  = calc_total(CHANNEL_NUM_IN, CHANNEL_NUM_OUT, KERNEL);
  localparam int PAIRS  = CHANNEL_NUM_OUT * CHANNEL_NUM_IN;
  localparam int CNT_W  = width_of(TOTAL);
  localparam int TAP_W  = width_of(TAPS);
  localparam int PAIR_W = width_of(PAIRS);

  localparam logic [TAP_W-1:0]      TAP_LAST  = TAP_W'(TAPS - 1);
  localparam logic [PAIR_W-1:0]     PAIR_LAST = PAIR_W'(PAIRS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic [TAP_W-1:0]  tap;
  logic [PAIR_W-1:0] pair;
  logic              issue;
  logic              done_int;
  logic              in_flight;
  logic              tag_last_kernel;
  logic              tag_last_weight;

  // Markers for the read about to be issued; pair counter only serves these
  assign tag_last_kernel = (tap == TAP_LAST);
  assign tag_last_weight = tag_last_kernel && (pair == PAIR_LAST);

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, read issue and completion; start only counts in IDLE
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done_int   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!hold) begin
          issue = 1'b1;
          if (tag_last_weight) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!in_flight) begin
          done_int   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Linear read counter plus tap/pair counters; all zeroed on an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      tap   <= '0;
      pair  <= '0;
    end else if (state == ST_IDLE && start) begin
      count <= '0;
      tap   <= '0;
      pair  <= '0;
    end else if (issue) begin
      count <= count + 1'b1;
      if (tag_last_kernel) begin
        tap  <= '0;
        pair <= pair + 1'b1;
      end else begin
        tap <= tap + 1'b1;
      end
    end
  end

  assign mem_rd_en = issue;
  assign mem_addr  = issue ? (BASE + ADDR_WIDTH'(count)) : '0;
  assign done      = done_int;
  assign busy      = (state != ST_IDLE) && !done_int;

  conv_weight_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (MEM_LATENCY)
  ) u_rd_pipe (
    .clk             (clk),
    .reset           (reset),
    .issue           (issue),
    .tag_last_kernel (tag_last_kernel),
    .tag_last_weight (tag_last_weight),
    .mem_rd_data     (mem_rd_data),
    .valid           (valid_weight_out),
    .data            (weight_out),
    .last_kernel     (last_kernel),
    .last_weight     (last_weight),
    .in_flight       (in_flight)
  );

endmodule

// File: tb/tb_conv_weight_stream_gen.sv
// Scoreboard bench: three generators (memory latency 1, 2, 4) share stimulus;
// a per-instance monitor checks every emitted weight against a reference queue.
module tb_conv_weight_stream_gen;

  localparam int CIN   = 2;
  localparam int COUT  = 2;
  localparam int KER   = 3;
  localparam int BASE  = 100;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int NI    = 3;
  localparam int TAPS  = KER * KER;
  localparam int TOTAL = CIN * COUT * TAPS;

  typedef struct packed {
    logic [DW-1:0] w;
    logic          lk;
    logic          lw;
  } exp_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          hold  = 1'b0;
  logic          start_w [NI];
  logic          rd_en_w [NI];
  logic [AW-1:0] addr_w  [NI];
  logic [DW-1:0] rdata_w [NI];
  logic          vld_w   [NI];
  logic [DW-1:0] wout_w  [NI];
  logic          lk_w    [NI];
  logic          lw_w    [NI];
  logic          busy_w  [NI];
  logic          done_w  [NI];

  exp_t   exp_q   [NI][$];
  longint issue_q [NI][$];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int rd_cnt    [NI];
  int out_cnt   [NI];
  int done_cnt  [NI];
  int first_cyc [NI];
  int last_cyc  [NI];
  int lw_cyc    [NI];
  int sets = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [63:0] outs_of(input int n);
    return {10'd0, rd_en_w[n], addr_w[n], vld_w[n], wout_w[n], lk_w[n], lw_w[n],
            busy_w[n], done_w[n]};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_lat
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    logic [DW-1:0] mem_pipe [LAT];
    logic          prev_done = 1'b0;
    exp_t          e;
    longint        t_iss;

    conv_weight_stream_gen #(
      .DATA_WIDTH      (DW),
      .CHANNEL_NUM_IN  (CIN),
      .CHANNEL_NUM_OUT (COUT),
      .KERNEL          (KER),
      .ADDR_WIDTH      (AW),
      .BASE_ADDR       (BASE),
      .MEM_LATENCY     (LAT)
    ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start_w[gi]),
      .hold             (hold),
      .mem_rd_en        (rd_en_w[gi]),
      .mem_addr         (addr_w[gi]),
      .mem_rd_data      (rdata_w[gi]),
      .valid_weight_out (vld_w[gi]),
      .weight_out       (wout_w[gi]),
      .last_kernel      (lk_w[gi]),
      .last_weight      (lw_w[gi]),
      .busy             (busy_w[gi]),
      .done             (done_w[gi])
    );

    // Weight memory model: word = address, returned LAT cycles after the read
    always @(posedge clk) begin
      mem_pipe[0] <= rd_en_w[gi] ? DW'(addr_w[gi]) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign rdata_w[gi] = mem_pipe[LAT-1];

    // Monitor: pop the reference queue whenever a weight is presented
    always @(negedge clk) begin
      if (reset) begin
        if (rd_en_w[gi]) begin
          issue_q[gi].push_back(longint'(cyc));
          rd_cnt[gi]++;
        end
        if (prev_done) check($sformatf("busy_after_done_L%0d", LAT), longint'(busy_w[gi]), 0);
        prev_done = done_w[gi];
        if (vld_w[gi]) begin
          out_cnt[gi]++;
          if (exp_q[gi].size() == 0) begin
            n_total++;
            $display("FAIL unexpected_weight_L%0d: got weight %0d, required no output (cycle %0d)",
                     LAT, wout_w[gi], cyc);
          end else begin
            e = exp_q[gi].pop_front();
            check($sformatf("weight_L%0d", LAT), longint'(wout_w[gi]), longint'(e.w));
            check($sformatf("last_kernel_L%0d_w%0d", LAT, e.w), longint'(lk_w[gi]), longint'(e.lk));
            check($sformatf("last_weight_L%0d_w%0d", LAT, e.w), longint'(lw_w[gi]), longint'(e.lw));
          end
          if (issue_q[gi].size() != 0) begin
            t_iss = issue_q[gi].pop_front();
            check($sformatf("latency_L%0d", LAT), longint'(cyc) - t_iss, longint'(LAT + 1));
          end
          if (first_cyc[gi] < 0) first_cyc[gi] = cyc;
          last_cyc[gi] = cyc;
          if (lw_w[gi]) lw_cyc[gi] = cyc;
        end else begin
          check($sformatf("markers_idle_L%0d", LAT), longint'({lk_w[gi], lw_w[gi]}), 0);
        end
        if (done_w[gi]) begin
          check($sformatf("done_delay_L%0d", LAT), longint'(cyc - lw_cyc[gi]), 1);
          check($sformatf("done_queue_empty_L%0d", LAT), longint'(exp_q[gi].size()), 0);
          done_cnt[gi]++;
        end
      end
    end
  end

  // Reference model: the full set in co / ci / tap order
  task automatic push_set();
    exp_t e;
    for (int n = 0; n < NI; n++) begin
      first_cyc[n] = -1;
      for (int co = 0; co < COUT; co++)
        for (int ci = 0; ci < CIN; ci++)
          for (int k = 0; k < TAPS; k++) begin
            e.w  = DW'(BASE + (co * CIN + ci) * TAPS + k);
            e.lk = (k == TAPS - 1);
            e.lw = (co == COUT - 1) && (ci == CIN - 1) && (k == TAPS - 1);
            exp_q[n].push_back(e);
          end
    end
    sets++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    for (int n = 0; n < NI; n++) start_w[n] = v;
  endtask

  task automatic pulse_start();
    set_start(1'b1);
    step();
    set_start(1'b0);
  endtask

  // mode 0: plain, 1: random hold, 2: raise start in each instance's done cycle
  task automatic wait_done(input int mode);
    bit all_done;
    for (int c = 0; c < 1500; c++) begin
      all_done = 1'b1;
      for (int n = 0; n < NI; n++) if (done_cnt[n] < sets) all_done = 1'b0;
      if (all_done) break;
      if (mode == 1) hold = ($urandom_range(0, 2) == 0);
      if (mode == 2) for (int n = 0; n < NI; n++) start_w[n] = done_w[n];
      step();
    end
    hold = 1'b0;
    set_start(1'b0);
    repeat (6) step();
    for (int n = 0; n < NI; n++) check($sformatf("sets_done_%0d", n), longint'(done_cnt[n]), longint'(sets));
  endtask

  int base_rd;
  int base_out;
  int saved_done [NI];

  initial begin
    set_start(1'b0);
    for (int n = 0; n < NI; n++) begin
      rd_cnt[n] = 0; out_cnt[n] = 0; done_cnt[n] = 0;
      first_cyc[n] = -1; last_cyc[n] = 0; lw_cyc[n] = 0;
    end
    repeat (3) step();
    for (int n = 0; n < NI; n++) check($sformatf("reset_outputs_%0d", n), longint'(outs_of(n)), 0);
    reset = 1'b1;
    step();

    // Full stream, no stall: 36 back-to-back weights
    push_set();
    pulse_start();
    wait_done(0);
    for (int n = 0; n < NI; n++)
      check($sformatf("gapless_span_%0d", n), longint'(last_cyc[n] - first_cyc[n]), longint'(TOTAL - 1));

    // Stall for 5 cycles after the 10th read
    base_rd = rd_cnt[0];
    push_set();
    pulse_start();
    repeat (10) step();
    check("reads_before_hold", longint'(rd_cnt[0] - base_rd), 10);
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int n = 0; n < NI; n++) check($sformatf("no_read_in_hold_%0d", n), longint'(rd_en_w[n]), 0);
      step();
    end
    hold = 1'b0;
    wait_done(0);

    // Random stalls over two sets
    for (int s = 0; s < 2; s++) begin
      push_set();
      pulse_start();
      wait_done(1);
    end

    // Starts during FETCH and in the done cycle are ignored
    push_set();
    pulse_start();
    repeat ($urandom_range(2, 20)) step();
    pulse_start();
    wait_done(2);
    push_set();
    pulse_start();
    wait_done(0);

    // Reset after 20 weights abandons the set
    push_set();
    pulse_start();
    base_out = out_cnt[1];
    for (int c = 0; c < 200 && (out_cnt[1] - base_out) < 20; c++) step();
    check("reached_20_weights", longint'(out_cnt[1] - base_out), 20);
    reset = 1'b0;
    #1;
    for (int n = 0; n < NI; n++) begin
      check($sformatf("midop_reset_outputs_%0d", n), longint'(outs_of(n)), 0);
      exp_q[n].delete();
      issue_q[n].delete();
      saved_done[n] = done_cnt[n];
    end
    sets--;
    repeat (2) step();
    reset = 1'b1;
    repeat (20) step();
    for (int n = 0; n < NI; n++)
      check($sformatf("no_done_after_reset_%0d", n), longint'(done_cnt[n]), longint'(saved_done[n]));
    push_set();
    pulse_start();
    wait_done(0);

    // hold already high when start arrives
    hold = 1'b1;
    push_set();
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      for (int n = 0; n < NI; n++) begin
        check($sformatf("hold_start_no_read_%0d", n), longint'(rd_en_w[n]), 0);
        check($sformatf("hold_start_busy_%0d", n), longint'(busy_w[n]), 1);
      end
      step();
    end
    hold = 1'b0;
    wait_done(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
